multi_channel_signal_shifter: RTL and testbench

Parametrised successor to the single-channel signal shifter. It delays NUM_CHANNELS independent digital inputs by per-channel programmable cycle delays, buffering up to MAX_EVENT pending edges per channel. It adds per-channel start/stop, edge-count limits, output polarity and overflow status. It sits behind the AXI register front-end on the same clock, in place of one shifter per I/O pin.

---
 rtl/multi_channel_signal_shifter.sv | 194 +++++++++++++++++++
 tb/tb_multi_channel_signal_shifter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_signal_shifter.sv
// Per-channel programmable delay line: input edges are time-stamped into a FIFO and replayed on output_signal exactly `delay` cycles later.
// No backpressure: an edge arriving at a full FIFO is dropped and flagged in the sticky overflow bit.

module mcss_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign out_vld = (r_count != '0);
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign out_dat = r_mem[r_rd_ptr];
    assign w_push  = in_vld && !full;
    assign w_pop   = out_rdy && out_vld;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_dat;
    end
endmodule

module multi_channel_signal_shifter #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int MAX_DELAY    = 1000000000,
    parameter int DELAY_WIDTH  = $clog2(MAX_DELAY),
    parameter int MAX_EVENT    = 16,
    parameter int MAX_COUNT    = 65535,
    parameter int COUNT_WIDTH  = $clog2(MAX_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH_WIDTH-1:0]     cfg_channel,
    input  logic [DELAY_WIDTH-1:0]  cfg_delay_value,
    input  logic                    cfg_delay_set,
    input  logic [COUNT_WIDTH-1:0]  cfg_event_value,
    input  logic                    cfg_event_set,
    input  logic                    cfg_polarity_value,
    input  logic                    cfg_polarity_set,
    input  logic                    auto_start,
    input  logic [NUM_CHANNELS-1:0] start_mask,
    input  logic [NUM_CHANNELS-1:0] stop_mask,
    input  logic [NUM_CHANNELS-1:0] input_signal,
    output logic [NUM_CHANNELS-1:0] output_signal,
    output logic [NUM_CHANNELS-1:0] busy,
    output logic [NUM_CHANNELS-1:0] overflow
);
    localparam int NOW_W = DELAY_WIDTH + 1;
    localparam logic [DELAY_WIDTH-1:0] DLY_MIN = DELAY_WIDTH'(2);
    localparam logic [DELAY_WIDTH-1:0] DLY_MAX = DELAY_WIDTH'(MAX_DELAY);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    logic [NOW_W-1:0]       r_now;
    logic [DELAY_WIDTH-1:0] w_delay_clamped;

    // Due times share the modulo of r_now, so equality matching survives wrap.
    always_ff @(posedge clk) begin
        if (reset) r_now <= '0;
        else       r_now <= r_now + 1'b1;
    end

    always_comb begin
        w_delay_clamped = cfg_delay_value;
        if (cfg_delay_value < DLY_MIN)      w_delay_clamped = DLY_MIN;
        else if (cfg_delay_value > DLY_MAX) w_delay_clamped = DLY_MAX;
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [DELAY_WIDTH-1:0] r_delay;
        logic [COUNT_WIDTH-1:0] r_limit;
        logic [COUNT_WIDTH-1:0] r_count;
        logic [COUNT_WIDTH-1:0] w_count_inc;
        logic                   r_pol;
        logic                   r_level;
        logic                   r_prev;
        logic                   r_ovf;
        logic                   r_out;
        logic                   w_sel;
        logic                   w_stop;
        logic                   w_start;
        logic                   w_edge;
        logic                   w_pop;
        logic                   w_fifo_vld;
        logic                   w_fifo_full;
        logic [NOW_W-1:0]       w_head;
        logic [NOW_W-1:0]       w_due;
        logic                   w_level_nxt;
        logic                   w_pol_nxt;

        assign w_sel       = (cfg_channel == CH_WIDTH'(g)) && (r_state == ST_IDLE);
        assign w_stop      = stop_mask[g];
        assign w_start     = (r_state == ST_IDLE) && !w_stop && (start_mask[g] || auto_start);
        assign w_edge      = (r_state == ST_RUN) && !w_stop && (input_signal[g] != r_prev);
        assign w_pop       = (r_state != ST_IDLE) && !w_stop && w_fifo_vld && (w_head == r_now);
        assign w_count_inc = r_count + 1'b1;
        assign w_due       = r_now + {1'b0, r_delay};
        assign w_level_nxt = w_start ? input_signal[g] : (r_level ^ w_pop);
        assign w_pol_nxt   = (w_sel && cfg_polarity_set) ? cfg_polarity_value : r_pol;

        mcss_fifo #(
            .WIDTH (NOW_W),
            .DEPTH (MAX_EVENT)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush   (w_stop),
            .in_vld  (w_edge),
            .in_dat  (w_due),
            .out_rdy (w_pop),
            .out_vld (w_fifo_vld),
            .out_dat (w_head),
            .full    (w_fifo_full)
        );

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
                ST_RUN:   if (w_edge && (r_limit != '0) && (w_count_inc == r_limit))
                              w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (!w_fifo_vld) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
            if (w_stop) w_state_nxt = ST_IDLE;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_delay <= DLY_MIN;
                r_limit <= '0;
                r_pol   <= 1'b0;
                r_level <= 1'b0;
                r_prev  <= 1'b0;
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_out   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_level <= w_level_nxt;
                r_pol   <= w_pol_nxt;
                r_out   <= w_level_nxt ^ w_pol_nxt;
                if (w_sel && cfg_delay_set) r_delay <= w_delay_clamped;
                if (w_sel && cfg_event_set) r_limit <= cfg_event_value;
                // A dropped edge still advances prev and the count toward the limit.
                if (w_start) begin
                    r_prev  <= input_signal[g];
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end else if (w_edge) begin
                    r_prev  <= input_signal[g];
                    r_count <= w_count_inc;
                    if (w_fifo_full) r_ovf <= 1'b1;
                end
            end
        end

        assign output_signal[g] = r_out;
        assign busy[g]          = (r_state != ST_IDLE);
        assign overflow[g]      = r_ovf;
    end
endmodule

// File: tb/tb_multi_channel_signal_shifter.sv
// Bench for multi_channel_signal_shifter: directed scenarios plus a random phase, all checked
// every cycle against an absolute-time event-queue model of each channel.
module tb_multi_channel_signal_shifter;
    localparam int NCH       = 4;
    localparam int MAX_DELAY = 200;
    localparam int DW        = $clog2(MAX_DELAY);
    localparam int MAX_EVENT = 16;
    localparam int CW        = 16;
    localparam int WRAP      = 1 << (DW + 1);
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     cfg_channel;
    logic [DW-1:0]  cfg_delay_value;
    logic           cfg_delay_set;
    logic [CW-1:0]  cfg_event_value;
    logic           cfg_event_set;
    logic           cfg_polarity_value;
    logic           cfg_polarity_set;
    logic           auto_start;
    logic [NCH-1:0] start_mask;
    logic [NCH-1:0] stop_mask;
    logic [NCH-1:0] input_signal;
    logic [NCH-1:0] output_signal;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] overflow;

    int n_checks = 0;
    int n_fail   = 0;

    multi_channel_signal_shifter #(
        .NUM_CHANNELS (NCH),
        .MAX_DELAY    (MAX_DELAY),
        .MAX_EVENT    (MAX_EVENT),
        .MAX_COUNT    (65535)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_channel        (cfg_channel),
        .cfg_delay_value    (cfg_delay_value),
        .cfg_delay_set      (cfg_delay_set),
        .cfg_event_value    (cfg_event_value),
        .cfg_event_set      (cfg_event_set),
        .cfg_polarity_value (cfg_polarity_value),
        .cfg_polarity_set   (cfg_polarity_set),
        .auto_start         (auto_start),
        .start_mask         (start_mask),
        .stop_mask          (stop_mask),
        .input_signal       (input_signal),
        .output_signal      (output_signal),
        .busy               (busy),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: absolute time, queue of due times ----------------
    int  m_st    [NCH];
    int  m_delay [NCH];
    int  m_limit [NCH];
    int  m_cnt   [NCH];
    bit  m_pol   [NCH];
    bit  m_level [NCH];
    bit  m_prev  [NCH];
    bit  m_ovf   [NCH];
    int  m_q     [NCH][$];
    int  m_now   = 0;
    bit  m_valid = 1'b0;
    bit  mb_full, mb_empty, mb_pop, mb_in;
    logic [NCH-1:0] e_out, e_busy, e_ovf;

    function automatic int clamp_delay(input int v);
        if (v < 2) return 2;
        if (v > MAX_DELAY) return MAX_DELAY;
        return v;
    endfunction

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (reset) begin
            m_now = 0;
            for (int c = 0; c < NCH; c++) begin
                m_st[c] = S_IDLE; m_delay[c] = 2; m_limit[c] = 0; m_cnt[c] = 0;
                m_pol[c] = 0; m_level[c] = 0; m_prev[c] = 0; m_ovf[c] = 0;
                m_q[c].delete();
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                mb_in    = input_signal[c];
                mb_full  = (m_q[c].size() == MAX_EVENT);
                mb_empty = (m_q[c].size() == 0);
                mb_pop   = (m_st[c] != S_IDLE) && !mb_empty && (m_q[c][0] == m_now);
                if (m_st[c] == S_IDLE && int'(cfg_channel) == c) begin
                    if (cfg_delay_set)    m_delay[c] = clamp_delay(int'(cfg_delay_value));
                    if (cfg_event_set)    m_limit[c] = int'(cfg_event_value);
                    if (cfg_polarity_set) m_pol[c]   = cfg_polarity_value;
                end
                if (stop_mask[c]) begin
                    m_st[c] = S_IDLE;
                    m_q[c].delete();
                end else begin
                    if (mb_pop) begin
                        void'(m_q[c].pop_front());
                        m_level[c] = !m_level[c];
                    end
                    case (m_st[c])
                        S_IDLE: if (start_mask[c] || auto_start) begin
                            m_st[c] = S_RUN; m_prev[c] = mb_in; m_level[c] = mb_in;
                            m_cnt[c] = 0; m_ovf[c] = 0;
                        end
                        S_RUN: if (mb_in != m_prev[c]) begin
                            m_prev[c] = mb_in;
                            m_cnt[c]++;
                            if (mb_full) m_ovf[c] = 1;
                            else         m_q[c].push_back(m_now + m_delay[c]);
                            if (m_limit[c] != 0 && m_cnt[c] == m_limit[c]) m_st[c] = S_DRAIN;
                        end
                        default: if (mb_empty) m_st[c] = S_IDLE;
                    endcase
                end
            end
            m_now++;
        end
        for (int c = 0; c < NCH; c++) begin
            e_out[c]  = m_level[c] ^ m_pol[c];
            e_busy[c] = (m_st[c] != S_IDLE);
            e_ovf[c]  = m_ovf[c];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out", output_signal, e_out);
            check("model_busy", busy, e_busy);
            check("model_ovf", overflow, e_ovf);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg_start(input int ch, input int dly, input int lim, input bit pol);
        cfg_channel        = 2'(ch);
        cfg_delay_value    = DW'(dly);
        cfg_delay_set      = 1'b1;
        cfg_event_value    = CW'(lim);
        cfg_event_set      = 1'b1;
        cfg_polarity_value = pol;
        cfg_polarity_set   = 1'b1;
        start_mask         = NCH'(1 << ch);
        @(negedge clk);
        cfg_delay_set = 1'b0; cfg_event_set = 1'b0; cfg_polarity_set = 1'b0;
        start_mask    = '0;
    endtask

    int toggles;
    logic prev_o;

    initial begin
        reset = 1'b1;
        cfg_channel = '0; cfg_delay_value = '0; cfg_delay_set = 1'b0;
        cfg_event_value = '0; cfg_event_set = 1'b0;
        cfg_polarity_value = 1'b0; cfg_polarity_set = 1'b0;
        auto_start = 1'b0; start_mask = '0; stop_mask = '0; input_signal = '0;
        repeat (3) @(negedge clk);
        check("reset_out", output_signal, 0);
        check("reset_busy", busy, 0);
        check("reset_ovf", overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        // ch0, delay 5: single rising edge
        cfg_start(0, 5, 0, 0);
        for (int m = 0; m < 8; m++) begin
            if (m == 0) input_signal[0] = 1'b1;
            @(negedge clk);
            if (m == 4) check("t1_before", output_signal[0], 0);
            if (m == 5) begin
                check("t1_rise", output_signal[0], 1);
                check("t1_others", output_signal[3:1], 0);
            end
        end

        // ch1, delay 2: 1-cycle pulse train
        cfg_start(1, 2, 0, 0);
        for (int m = 0; m < 10; m++) begin
            if (m < 6) input_signal[1] = ~input_signal[1];
            @(negedge clk);
            if (m == 1) check("t2_c1", output_signal[1], 0);
            if (m == 2) check("t2_c2", output_signal[1], 1);
            if (m == 3) check("t2_c3", output_signal[1], 0);
        end
        check("t2_no_ovf", overflow[1], 0);

        // ch2, delay 100, limit 20: 20 edges into a 16-deep FIFO
        cfg_start(2, 100, 20, 0);
        toggles = 0;
        prev_o  = output_signal[2];
        for (int m = 0; m < 121; m++) begin
            if (m < 20) input_signal[2] = ~input_signal[2];
            @(negedge clk);
            if (output_signal[2] != prev_o) toggles++;
            prev_o = output_signal[2];
            if (m == 20)  check("t3_ovf", overflow[2], 1);
            if (m == 115) check("t3_busy_last_pop", busy[2], 1);
            if (m == 116) check("t3_busy_fall", busy[2], 0);
        end
        check("t3_toggles", toggles, 16);

        // ch3, delay 4, limit 3, inverted polarity, 5 edges
        cfg_start(3, 4, 3, 1);
        check("t4_idle_inv", output_signal[3], 1);
        for (int m = 0; m < 13; m++) begin
            if (m == 0 || m == 2 || m == 4 || m == 6 || m == 8) input_signal[3] = ~input_signal[3];
            @(negedge clk);
            if (m == 3)  check("t4_pre", output_signal[3], 1);
            if (m == 4)  check("t4_first", output_signal[3], 0);
            if (m == 8)  check("t4_busy", busy[3], 1);
            if (m == 9)  check("t4_busy_fall", busy[3], 0);
            if (m == 11) check("t4_no_4th", output_signal[3], 0);
        end

        // ch0 across the counter wrap, delay 10; a delay write during RUN is ignored
        stop_mask = 4'b0001;
        @(negedge clk);
        stop_mask = '0;
        for (int w = 0; w < 2000 && (m_now % WRAP) != WRAP - 6; w++) @(negedge clk);
        check("t5_wait", m_now % WRAP, WRAP - 6);
        cfg_start(0, 10, 0, 0);
        for (int m = 0; m < 16; m++) begin
            if (m == 1) begin
                cfg_channel = 2'd0; cfg_delay_value = DW'(50); cfg_delay_set = 1'b1;
            end
            if (m == 2) begin
                cfg_delay_set   = 1'b0;
                input_signal[0] = 1'b0;
            end
            @(negedge clk);
            if (m == 11) check("t5_before", output_signal[0], 1);
            if (m == 12) check("t5_toggle", output_signal[0], 0);
        end

        // ch1 stopped with 4 edges pending
        stop_mask = 4'b0010;
        @(negedge clk);
        stop_mask = '0;
        cfg_start(1, 20, 0, 0);
        for (int m = 0; m < 31; m++) begin
            if (m < 4)  input_signal[1] = ~input_signal[1];
            if (m == 6) stop_mask = 4'b0010;
            if (m == 7) stop_mask = '0;
            @(negedge clk);
            if (m == 5)  check("t6_busy", busy[1], 1);
            if (m == 6)  check("t6_busy_fall", busy[1], 0);
            if (m == 20) check("t6_frozen", output_signal[1], 0);
            if (m == 21) check("t6_frozen2", output_signal[1], 0);
        end

        // random phase
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0)  input_signal[c] = ~input_signal[c];
                start_mask[c] = ($urandom_range(0, 39) == 0);
                stop_mask[c]  = ($urandom_range(0, 99) == 0);
            end
            auto_start = ($urandom_range(0, 49) == 0);
            cfg_channel = 2'($urandom_range(0, 3));
            cfg_delay_value = DW'($urandom_range(0, 255));
            cfg_event_value = CW'($urandom_range(0, 6));
            cfg_polarity_value = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                cfg_delay_set    = 1'($urandom_range(0, 1));
                cfg_event_set    = 1'($urandom_range(0, 1));
                cfg_polarity_set = 1'($urandom_range(0, 1));
            end else begin
                cfg_delay_set = 1'b0; cfg_event_set = 1'b0; cfg_polarity_set = 1'b0;
            end
            @(negedge clk);
        end
        cfg_delay_set = 1'b0; cfg_event_set = 1'b0; cfg_polarity_set = 1'b0;
        auto_start = 1'b0; stop_mask = '0;

        // reset while running, then default delay of 2
        start_mask = '1;
        @(negedge clk);
        start_mask = '0;
        for (int m = 0; m < 4; m++) begin
            input_signal = ~input_signal;
            @(negedge clk);
        end
        reset = 1'b1;
        input_signal = '0;
        @(negedge clk);
        check("t7_rst_out", output_signal, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_ovf", overflow, 0);
        reset = 1'b0;
        start_mask = 4'b0001;
        @(negedge clk);
        start_mask = '0;
        for (int m = 0; m < 4; m++) begin
            if (m == 0) input_signal[0] = 1'b1;
            @(negedge clk);
            if (m == 1) check("t7_dly_before", output_signal[0], 0);
            if (m == 2) check("t7_dly_default", output_signal[0], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
